imem_dual_responder: RTL

- Dual-channel instruction-memory responder for the superscalar fetch path.
- Consumes the two fetch request streams (Inst1_Req, Inst2_Req) and returns the matching responses (Inst1_Resp, Inst2_Resp) after a programmable wait.
- Backed by a word array written through a load port.
- Sits directly downstream of fetch. Used as the memory side of the simulation environment and as the synthesizable boot ROM.

---
 rtl/imem_dual_responder_pkg.sv | 40 ++++
 rtl/imem_dual_responder_channel.sv | 122 ++++++++++++
 rtl/imem_dual_responder.sv | 73 +++++++
 3 files changed

// File: rtl/imem_dual_responder_pkg.sv
// Shared types and defaults for imem_dual_responder: channel states, LFSR seeds and
// the pack/unpack helpers between flat ports and Mem_Req / Mem_Respond structs.
package imem_dual_responder_pkg;

  localparam int IMEM_DEPTH   = 1024;
  localparam int IMEM_LATENCY = 2;
  localparam int IMEM_ADDR_W  = 32;

  localparam logic [15:0] IMEM_LFSR_SEED0 = 16'hACE1;
  localparam logic [15:0] IMEM_LFSR_SEED1 = 16'h1D2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  typedef struct packed {
    logic                   valid;
    logic [IMEM_ADDR_W-1:0] addr;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } mem_respond_t;

  function automatic mem_req_t unpack_req(input logic valid, input logic [IMEM_ADDR_W-1:0] addr);
    mem_req_t r;
    r.valid = valid;
    r.addr  = addr;
    return r;
  endfunction

  function automatic logic [33:0] pack_resp(input mem_respond_t r);
    return {r.valid, r.data, r.err};
  endfunction

endpackage

// File: rtl/imem_dual_responder_channel.sv
// One fetch channel of imem_dual_responder: IDLE -> WAIT -> RESP with a holding register.
// Defining IMEM_RANDOM_DELAY_EN replaces the fixed wait with an LFSR-derived 1..LATENCY wait.
module imem_channel
  import imem_dual_responder_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int LATENCY = IMEM_LATENCY,
  parameter int ADDR_W  = IMEM_ADDR_W
`ifdef IMEM_RANDOM_DELAY_EN
  ,
  parameter logic [15:0] SEED = IMEM_LFSR_SEED0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_req_ready,
  input  logic [31:0]       i_rd_data,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_data,
  output logic              o_resp_err,
  input  logic              i_resp_ready
);

  localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(DEPTH * 4);

  imem_state_e r_state;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;

  logic        w_err;
  logic        w_accept;
  logic [3:0]  w_wait_load;

  assign w_err    = (i_req_addr[1:0] != 2'b00) || (i_req_addr >= BYTE_LIMIT);
  assign w_accept = i_req_valid && o_req_ready;

`ifdef IMEM_RANDOM_DELAY_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_wait_load = 4'(32'(r_lfsr[3:0]) % LATENCY);

  // LFSR steps once per accepted request so the delay sequence repeats after every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  assign w_wait_load = 4'(LATENCY - 1);
`endif

  // Ready follows resp_ready in RESP so a response can retire and a new request enter together.
  always_comb begin
    case (r_state)
      IDLE:    o_req_ready = 1'b1;
      RESP:    o_req_ready = i_resp_ready;
      default: o_req_ready = 1'b0;
    endcase
  end

  // Channel FSM; the word is captured at acceptance so later loads cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= w_err ? 32'd0 : i_rd_data;
            r_err   <= w_err;
            r_cnt   <= w_wait_load;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_valid <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_valid <= 1'b0;
            if (w_accept) begin
              r_data  <= w_err ? 32'd0 : i_rd_data;
              r_err   <= w_err;
              r_cnt   <= w_wait_load;
              r_state <= WAIT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_resp_valid = r_valid;
  assign o_resp_data  = r_data;
  assign o_resp_err   = r_err;

endmodule

// File: rtl/imem_dual_responder.sv
// Dual-channel instruction-memory responder: word array, load port and two imem_channel
// instances. Optional macro IMEM_RANDOM_DELAY_EN enables per-channel random wait.
module imem_dual_responder
  import imem_dual_responder_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int LATENCY = IMEM_LATENCY,
  parameter int ADDR_W  = IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             req_ready,
  output logic [1:0]             resp_valid,
  output logic [1:0][31:0]       resp_data,
  output logic [1:0]             resp_err,
  input  logic [1:0]             resp_ready,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [31:0]            load_data
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(DEPTH * 4);

  logic [31:0]      r_mem [DEPTH];
  logic             w_load_ok;
  logic [IDX_W-1:0] w_load_idx;

  assign w_load_ok  = load_en && (load_addr < BYTE_LIMIT);
  assign w_load_idx = load_addr[IDX_W+1:2];

  // Array write port; contents survive reset and out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    mem_req_t     w_req;
    mem_respond_t w_resp;
    logic [31:0]  w_rd_data;

    assign w_req     = unpack_req(req_valid[g], req_addr[g]);
    assign w_rd_data = r_mem[w_req.addr[IDX_W+1:2]];

    imem_channel #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY),
      .ADDR_W  (ADDR_W)
`ifdef IMEM_RANDOM_DELAY_EN
      ,
      .SEED    ((g == 0) ? IMEM_LFSR_SEED0 : IMEM_LFSR_SEED1)
`endif
    ) u_channel (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (w_req.valid),
      .i_req_addr   (w_req.addr),
      .o_req_ready  (req_ready[g]),
      .i_rd_data    (w_rd_data),
      .o_resp_valid (w_resp.valid),
      .o_resp_data  (w_resp.data),
      .o_resp_err   (w_resp.err),
      .i_resp_ready (resp_ready[g])
    );

    assign {resp_valid[g], resp_data[g], resp_err[g]} = pack_resp(w_resp);
  end

endmodule
